spi_adc_scanner: RTL
====================

# spi_adc_scanner

Parametrised multi-channel SPI ADC master that replaces the single-channel serial ADC reader in `top`. It drives one shared `sclk`, one `cs_n` per ADC and one shared `sdata` return line. It scans the enabled channels in ascending order, either once per `start` pulse or continuously. Each captured conversion is presented as a tagged one-cycle sample for the display, UART and heater/motor control paths.

## Interface
- `DATA_W`, 12 — conversion result width, MSB first on `sdata`.
- `NUM_CH`, 4 — number of ADCs, one `cs_n` bit each; must be ≥1.
- `FRAME_BITS`, 16 — `sclk` periods per frame; must be ≥ `LEAD_BITS + DATA_W`.
- `LEAD_BITS`, 4 — leading bits discarded before the data MSB.
- `CLK_DIV`, 4 — `clk` cycles per `sclk` half-period; must be ≥2.
- `CS_IDLE`, 4 — `clk` cycles with all `cs_n` high between frames; must be ≥1.
- `CH_W`, `$clog2(NUM_CH)` (min 1) — channel tag width.

- `clk` in 1 — system clock; all logic on rising edge.
- `n_rst` in 1 — asynchronous, active-low reset.
- `start` in 1 — one-cycle request to begin a scan; sampled only in IDLE.
- `cont` in 1 — continuous mode: after the last enabled channel, wrap to the first.
- `ch_mask` in `NUM_CH` — channel enables, bit i = ADC i; sampled at every channel selection.
- `sdata` in 1 — serial data from the ADCs.
- `sclk` out 1 — SPI clock; idles high (CPOL=1).
- `cs_n` out `NUM_CH` — per-ADC chip select, active low; at most one bit low at any time.
- `sample` out `DATA_W` — last captured result.
- `sample_ch` out `CH_W` — channel index of `sample`.
- `sample_valid` out 1 — one-cycle pulse when `sample` and `sample_ch` update.
- `busy` out 1 — high from scan start until return to IDLE.
- `done` out 1 — one-cycle pulse on return to IDLE.

## Operation
- **Reset values:** `sclk`=1, `cs_n`=all 1, `sample`=0, `sample_ch`=0, `sample_valid`=0, `busy`=0, `done`=0, state IDLE.
- **States:** IDLE → SETUP → SHIFT → HOLD → (SETUP for the next channel | IDLE).
- **IDLE:** `start`=1 with `ch_mask`≠0 selects the lowest set mask bit and enters SETUP. `start` with `ch_mask`=0 is ignored: no `busy`, no `done`.
- **SETUP:** `cs_n[ch]`=0, `sclk`=1, lasting `CLK_DIV` cycles.
- **SHIFT:** for each bit k = 0..`FRAME_BITS`-1:
  - `sclk`=0 for `CLK_DIV` cycles, then `sclk`=1 for `CLK_DIV` cycles.
  - `sdata` is registered on the `clk` edge that raises `sclk`.
  - Bits with `LEAD_BITS` ≤ k < `LEAD_BITS+DATA_W` shift into the data register MSB first. All other bits are discarded.
- **End of SHIFT (after the last high phase):**
  - All `cs_n` go high.
  - `sample` and `sample_ch` load, and `sample_valid`=1 for that one cycle.
  - State moves to HOLD.
- **HOLD:** lasts `CS_IDLE` cycles. On exit, the next channel is the lowest set bit of the current `ch_mask` with index > the current channel.
  - If no such bit exists and `cont`=1: wrap to the lowest set bit.
  - If no such bit exists and `cont`=0: go to IDLE, `busy`=0, `done`=1 for one cycle.
  - If `ch_mask`=0 at HOLD exit (either mode): go to IDLE with `done`.
- **Mid-scan changes:** `ch_mask` and `cont` changes take effect only at HOLD exit; the frame in progress always completes.
- **`start` while busy** is ignored.
- **Reset mid-frame:** immediately returns all outputs to reset values and discards the partial result.
- **No backpressure:** the consumer must accept each `sample_valid` pulse.

## Timing
- Clocks per channel frame = `CLK_DIV` + 2·`CLK_DIV`·`FRAME_BITS` + `CS_IDLE`; defaults give 4+128+4 = 136.
- Latency from `start` high to `busy`=1 and `cs_n` low: 1 clk.
- First falling edge of `sclk`: `CLK_DIV` cycles after `cs_n` falls.
- Latency from `start` to the first `sample_valid`: 1 + `CLK_DIV` + 2·`CLK_DIV`·`FRAME_BITS` = 133 (defaults).
- `done` occurs `CS_IDLE` cycles after the last `sample_valid`, in the same cycle `busy` falls.
- `sdata` must be stable for ≥1 `clk` before the rising `sclk` edge. ADCs change data on falling `sclk`, which gives `CLK_DIV`−1 cycles of setup margin.
- `sclk` and `cs_n` are registered outputs, glitch-free.

## Test plan
- **Reset:** hold `n_rst`=0 → `sclk`=1, `cs_n`=4'hF, `busy`=0, `sample`=0. Pulse `start` with `ch_mask`=0 → no `busy`, no `done`.
- **Single channel:** `ch_mask`=4'b0001, `cont`=0, slave 0 returns 4'b0000 then 12'hA5C → one `sample_valid` at 133 clks after `start`, `sample`=12'hA5C, `sample_ch`=0. `done` follows 4 clks later. Exactly 16 falling `sclk` edges.
- **Sparse mask:** `ch_mask`=4'b0101, ch0=12'h123, ch2=12'hFFF → samples (0,12'h123) then (2,12'hFFF), 136 clks apart. `cs_n[1]` and `cs_n[3]` never go low.
- **Continuous mode:** `ch_mask`=4'b1000, `cont`=1 → `sample_ch`=3 repeats every 136 clks. Drop `cont` → the current frame completes, then `done`. Clear `ch_mask` mid-frame → frame completes, then `done`.
- **Reset mid-SHIFT** (bit 7 of ch1) → next clk `cs_n`=4'hF, `sclk`=1, no `sample_valid`. A subsequent scan returns correct data.
- **Parameter variant:** `DATA_W`=10, `NUM_CH`=2, `FRAME_BITS`=12, `LEAD_BITS`=1, `CLK_DIV`=2, value 10'h2AA → `sample`=10'h2AA after 1+2+48 = 51 clks.

Source files
------------

// File: rtl/spi_adc_scanner.sv
// spi_adc_scanner: multi-channel SPI ADC master (CPOL=1, one cs_n per ADC).
// Scans enabled channels in ascending order, once per start or continuously.
// Ports: clk, n_rst (async low) | start, cont, ch_mask, sdata in
//        sclk, cs_n out (registered) | sample, sample_ch, sample_valid out
//        busy, done status out
module spi_adc_scanner #(
  parameter int DATA_W     = 12,
  parameter int NUM_CH     = 4,
  parameter int FRAME_BITS = 16,
  parameter int LEAD_BITS  = 4,
  parameter int CLK_DIV    = 4,
  parameter int CS_IDLE    = 4,
  parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic              cont,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              sdata,
  output logic              sclk,
  output logic [NUM_CH-1:0] cs_n,
  output logic [DATA_W-1:0] sample,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic              busy,
  output logic              done
);

  localparam int CNT_MAX = (CLK_DIV > CS_IDLE) ? CLK_DIV : CS_IDLE;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int BIT_W   = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic               sclk_d;
  logic [NUM_CH-1:0]  cs_d;
  logic [DATA_W-1:0]  sample_d;
  logic [CH_W-1:0]    sch_d;
  logic               valid_d;
  logic               busy_d;
  logic               done_d;
  logic [CH_W:0]      nxt;
  logic [CH_W:0]      wrap;
  logic               last_div;
  logic               last_hold;
  logic               in_win;

  // {found, index} of the lowest set mask bit at or above lo
  function automatic logic [CH_W:0] pick(
    input logic [NUM_CH-1:0] m,
    input int                lo
  );
    logic [CH_W:0] r;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && i >= lo) r = {1'b1, CH_W'(i)};
    end
    return r;
  endfunction

  function automatic logic [NUM_CH-1:0] sel(
    input logic [CH_W-1:0] c
  );
    return ~(NUM_CH'(1) << c);
  endfunction

  assign last_div  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign last_hold = (cnt_q == CNT_W'(CS_IDLE - 1));
  assign in_win    = (int'(bit_q) >= LEAD_BITS) &&
                     (int'(bit_q) < LEAD_BITS + DATA_W);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    ch_d     = ch_q;
    shreg_d  = shreg_q;
    sclk_d   = sclk;
    cs_d     = cs_n;
    sample_d = sample;
    sch_d    = sample_ch;
    valid_d  = 1'b0;
    busy_d   = busy;
    done_d   = 1'b0;
    nxt      = '0;
    wrap     = '0;
    unique case (state_q)
      IDLE: begin
        nxt = pick(ch_mask, 0);
        if (start && nxt[CH_W]) begin
          state_d = SETUP;
          ch_d    = nxt[CH_W-1:0];
          cs_d    = sel(nxt[CH_W-1:0]);
          busy_d  = 1'b1;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      SETUP: begin
        if (last_div) begin
          state_d = SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (!last_div) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!sclk) begin
            // rising sclk edge: capture the bit the ADC set up
            sclk_d = 1'b1;
            if (in_win) shreg_d = {shreg_q[DATA_W-2:0], sdata};
          end else if (bit_q == BIT_W'(FRAME_BITS - 1)) begin
            state_d  = HOLD;
            cs_d     = '1;
            sample_d = shreg_q;
            sch_d    = ch_q;
            valid_d  = 1'b1;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            sclk_d = 1'b0;
          end
        end
      end
      HOLD: begin
        if (!last_hold) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          nxt   = pick(ch_mask, int'(ch_q) + 1);
          wrap  = pick(ch_mask, 0);
          if (nxt[CH_W]) begin
            state_d = SETUP;
            ch_d    = nxt[CH_W-1:0];
            cs_d    = sel(nxt[CH_W-1:0]);
            shreg_d = '0;
          end else if (cont && wrap[CH_W]) begin
            state_d = SETUP;
            ch_d    = wrap[CH_W-1:0];
            cs_d    = sel(wrap[CH_W-1:0]);
            shreg_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      ch_q         <= '0;
      shreg_q      <= '0;
      sclk         <= 1'b1;
      cs_n         <= '1;
      sample       <= '0;
      sample_ch    <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      ch_q         <= ch_d;
      shreg_q      <= shreg_d;
      sclk         <= sclk_d;
      cs_n         <= cs_d;
      sample       <= sample_d;
      sample_ch    <= sch_d;
      sample_valid <= valid_d;
      busy         <= busy_d;
      done         <= done_d;
    end
  end

endmodule
